// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_BPC_1 = 1;
  localparam int unsigned DIV_BPC_2 = 2;
  localparam int unsigned DIV_BPC_4 = 4;

  // Widest operand the magnitude helper handles; callers sign-extend into it.
  localparam int unsigned DIV_MAX_W = 128;

  function automatic logic [DIV_MAX_W-1:0] div_abs(input logic [DIV_MAX_W-1:0] x,
                                                    input logic is_unsigned);
    return (x[DIV_MAX_W-1] && !is_unsigned) ? -x : x;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result handshake bundle between the execute stage and the divider.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             unsigned_flag;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divider;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_valid_pre;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [TAG_W-1:0] out_tag;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, unsigned_flag, dividend, divider, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_valid_pre, quotient, remainder, out_tag,
           div_by_zero, overflow, busy
  );

  modport slave (
    input  in_valid, unsigned_flag, dividend, divider, in_tag, flush, out_ready,
    output in_ready, out_valid, out_valid_pre, quotient, remainder, out_tag,
           div_by_zero, overflow, busy
  );
endinterface

// File: rtl/div_step.sv
// Combinational block of BPC restoring division steps on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // quo holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
  always_comb begin
    rem_out = rem_in;
    quo_out = quo_in;
    trial   = '0;
    diff    = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      trial   = {rem_out, quo_out[WIDTH-1]};
      diff    = trial - {1'b0, dvs};
      quo_out = {quo_out[WIDTH-2:0], ~diff[WIDTH]};
      rem_out = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned divider with valid/ready handshakes, flush and tag passthrough.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 5
) (
  input logic     clk,
  input logic     reset,
  div_iter_if.slave io
);
  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 8 || WIDTH > DIV_MAX_W ||
      !(BPC == DIV_BPC_1 || BPC == DIV_BPC_2 || BPC == DIV_BPC_4) ||
      (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("div_iter: illegal WIDTH/BPC combination");
  end

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_s, quo_s;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             q_neg, r_neg;
  logic [TAG_W-1:0] tag_q;
  logic             ready_c, accept, is_zero, is_ovf, corner, last_step;

  logic             out_valid_q, pre_q, dz_q, ov_q, busy_q;
  logic [WIDTH-1:0] quot_q, remd_q;
  logic [TAG_W-1:0] otag_q;

  assign is_zero   = io.divider == '0;
  assign is_ovf    = !io.unsigned_flag && io.dividend == MIN_VAL && io.divider == '1;
  assign corner    = is_zero || is_ovf;
  assign accept    = io.in_valid && ready_c;
  assign last_step = state == CALC && cnt == CW'(1);
  assign dvd_abs   = WIDTH'(div_abs(DIV_MAX_W'($signed(io.dividend)), io.unsigned_flag));
  assign dvs_abs   = WIDTH'(div_abs(DIV_MAX_W'($signed(io.divider)), io.unsigned_flag));

  div_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .dvs    (dvs_q),
    .rem_out(rem_s),
    .quo_out(quo_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (io.flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_nxt = corner ? DONE : CALC;
        CALC: if (cnt == CW'(1)) state_nxt = DONE;
        DONE: begin
          if (accept)            state_nxt = corner ? DONE : CALC;
          else if (io.out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_c = 1'b0;
    if (!io.flush) ready_c = (state == IDLE) || (state == DONE && io.out_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      pre_q       <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      busy_q      <= 1'b0;
      quot_q      <= '0;
      remd_q      <= '0;
      otag_q      <= '0;
    end else begin
      busy_q      <= state_nxt != IDLE;
      out_valid_q <= state_nxt == DONE;
      // Pre-valid lands in the final CALC cycle, so it is set one edge earlier (cnt==2).
      pre_q       <= state_nxt == CALC && state == CALC && cnt == CW'(2);
      if (accept) begin
        tag_q <= io.in_tag;
        q_neg <= !io.unsigned_flag && (io.dividend[WIDTH-1] ^ io.divider[WIDTH-1]);
        r_neg <= !io.unsigned_flag && io.dividend[WIDTH-1];
        dvs_q <= dvs_abs;
        quo_q <= dvd_abs;
        rem_q <= '0;
        cnt   <= CW'(N);
        if (corner) begin
          quot_q <= is_zero ? '1 : MIN_VAL;
          remd_q <= is_zero ? io.dividend : '0;
          dz_q   <= is_zero;
          ov_q   <= !is_zero;
          otag_q <= io.in_tag;
        end
      end else if (state == CALC && !io.flush) begin
        rem_q <= rem_s;
        quo_q <= quo_s;
        cnt   <= cnt - CW'(1);
        if (last_step) begin
          quot_q <= q_neg ? -quo_s : quo_s;
          remd_q <= r_neg ? -rem_s : rem_s;
          dz_q   <= 1'b0;
          ov_q   <= 1'b0;
          otag_q <= tag_q;
        end
      end
    end
  end

  assign io.in_ready      = ready_c;
  assign io.out_valid     = out_valid_q;
  assign io.out_valid_pre = pre_q;
  assign io.quotient      = quot_q;
  assign io.remainder     = remd_q;
  assign io.out_tag       = otag_q;
  assign io.div_by_zero   = dz_q;
  assign io.overflow      = ov_q;
  assign io.busy          = busy_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench: BPC=1 and BPC=4 dividers run side by side against an arithmetic model.
module tb_div_iter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32), .TAG_W(5)) if1 ();
  div_iter_if #(.WIDTH(32), .TAG_W(5)) if4 ();

  div_iter #(.WIDTH(32), .BPC(1), .TAG_W(5)) u_div1 (.clk(clk), .reset(rst_n), .io(if1));
  div_iter #(.WIDTH(32), .BPC(4), .TAG_W(5)) u_div4 (.clk(clk), .reset(rst_n), .io(if4));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  function automatic res_t ref_div(input logic uf, input logic [31:0] a, input logic [31:0] b);
    res_t x;
    x.dz = 1'b0;
    x.ov = 1'b0;
    if (b == 32'd0) begin
      x.q = 32'hFFFF_FFFF; x.r = a; x.dz = 1'b1;
    end else if (!uf && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.q = a; x.r = 32'd0; x.ov = 1'b1;
    end else if (uf) begin
      x.q = a / b; x.r = a % b;
    end else begin
      x.q = $signed(a) / $signed(b); x.r = $signed(a) % $signed(b);
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic uf, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg);
    if1.in_valid = v; if1.unsigned_flag = uf; if1.dividend = a; if1.divider = b; if1.in_tag = tg;
    if4.in_valid = v; if4.unsigned_flag = uf; if4.dividend = a; if4.divider = b; if4.in_tag = tg;
  endtask

  task automatic set_ctl(input logic fl, input logic ordy);
    if1.flush = fl; if1.out_ready = ordy;
    if4.flush = fl; if4.out_ready = ordy;
  endtask

  // Caller is at a falling edge with both dividers able to accept; returns just after the accept edge.
  task automatic issue(input logic uf, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    set_req(1'b1, uf, a, b, tg);
    #1;
    chk("in_ready1", if1.in_ready, 1);
    chk("in_ready4", if4.in_ready, 1);
    @(posedge clk);
  endtask

  task automatic watch(input logic uf, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input string nm);
    res_t e;
    bit corner;
    int unsigned v1, p1, v4, p4;
    logic [37:0] o1, o4;
    logic [31:0] q1, r1, q4, r4;
    e = ref_div(uf, a, b);
    corner = e.dz || e.ov;
    v1 = 0; p1 = 0; v4 = 0; p4 = 0;
    o1 = '0; o4 = '0; q1 = '0; r1 = '0; q4 = '0; r4 = '0;
    for (int unsigned k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      if (if1.out_valid && v1 == 0) begin
        v1 = k; q1 = if1.quotient; r1 = if1.remainder;
        o1 = {31'd0, if1.div_by_zero, if1.overflow, if1.out_tag};
      end
      if (if4.out_valid && v4 == 0) begin
        v4 = k; q4 = if4.quotient; r4 = if4.remainder;
        o4 = {31'd0, if4.div_by_zero, if4.overflow, if4.out_tag};
      end
      if (if1.out_valid_pre && p1 == 0) p1 = k;
      if (if4.out_valid_pre && p4 == 0) p4 = k;
    end
    chk({nm, "/lat1"}, v1, corner ? 1 : 33);
    chk({nm, "/pre1"}, p1, corner ? 0 : 32);
    chk({nm, "/lat4"}, v4, corner ? 1 : 9);
    chk({nm, "/pre4"}, p4, corner ? 0 : 8);
    chk({nm, "/q1"}, q1, e.q);
    chk({nm, "/r1"}, r1, e.r);
    chk({nm, "/q4"}, q4, e.q);
    chk({nm, "/r4"}, r4, e.r);
    chk({nm, "/flags_tag1"}, o1, {31'd0, e.dz, e.ov, tg});
    chk({nm, "/flags_tag4"}, o4, {31'd0, e.dz, e.ov, tg});
  endtask

  function automatic logic [95:0] snap1();
    return {if1.out_valid, if1.quotient, if1.remainder, if1.out_tag, if1.div_by_zero, if1.overflow};
  endfunction

  function automatic logic [95:0] snap4();
    return {if4.out_valid, if4.quotient, if4.remainder, if4.out_tag, if4.div_by_zero, if4.overflow};
  endfunction

  initial begin
    logic [95:0] s1, s4;
    logic [31:0] ra, rb;
    logic        ruf;
    bit          seen;
    int unsigned k;
    res_t        e;

    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    set_ctl(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("reset_out1", {if1.out_valid, if1.out_valid_pre, if1.quotient, if1.remainder, if1.out_tag,
                       if1.div_by_zero, if1.overflow, if1.busy}, '0);
    chk("reset_out4", {if4.out_valid, if4.out_valid_pre, if4.quotient, if4.remainder, if4.out_tag,
                       if4.div_by_zero, if4.overflow, if4.busy}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(1'b0, 32'd7, 32'hFFFF_FFFE, 5'd1);          watch(1'b0, 32'd7, 32'hFFFF_FFFE, 5'd1, "s7_m2");
    issue(1'b1, 32'hFFFF_FFFF, 32'd16, 5'd2);         watch(1'b1, 32'hFFFF_FFFF, 32'd16, 5'd2, "u_ff_16");
    issue(1'b1, 32'd100, 32'd0, 5'd3);                watch(1'b1, 32'd100, 32'd0, 5'd3, "dz");
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);  watch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, "ovf");
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5);          watch(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5, "sm7_2");

    // Randomised cases.
    for (int i = 0; i < 12; i++) begin
      ruf = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = -$urandom_range(1, 300);
        default: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
      endcase
      issue(ruf, ra, rb, 5'(i + 8));
      watch(ruf, ra, rb, 5'(i + 8), "rand");
    end

    // Backpressure: results held, then back-to-back accept in the release cycle.
    set_ctl(1'b0, 1'b0);
    issue(1'b1, 32'd1000, 32'd7, 5'd9);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    k = 0;
    while (!(if1.out_valid && if4.out_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("bp_wait", {if1.out_valid, if4.out_valid}, 2'b11);
    e = ref_div(1'b1, 32'd1000, 32'd7);
    chk("bp_q1", if1.quotient, e.q);
    chk("bp_r4", if4.remainder, e.r);
    s1 = snap1();
    s4 = snap4();
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold1", snap1(), s1);
      chk("bp_hold4", snap4(), s4);
    end
    set_ctl(1'b0, 1'b1);
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6);
    watch(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6, "b2b");

    // Flush at CALC step 10.
    issue(1'b1, 32'd12345, 32'd17, 5'd7);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (9) @(negedge clk);
    set_ctl(1'b1, 1'b1);
    #1;
    chk("flush_gates_ready", if4.in_ready, 0);
    @(negedge clk);
    set_ctl(1'b0, 1'b1);
    chk("flush_idle1", {if1.out_valid, if1.busy}, 2'b00);
    chk("flush_idle4", {if4.out_valid, if4.busy}, 2'b00);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (if1.out_valid || if1.out_valid_pre) seen = 1'b1;
    end
    chk("flush_no_result", seen, 0);

    // Reset pulsed mid-CALC.
    issue(1'b0, 32'd99999, 32'hFFFF_FFFD, 5'd10);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid1", {if1.out_valid, if1.out_valid_pre, if1.quotient, if1.remainder, if1.out_tag,
                     if1.div_by_zero, if1.overflow, if1.busy}, '0);
    chk("rst_mid4", {if4.out_valid, if4.out_valid_pre, if4.quotient, if4.remainder, if4.out_tag,
                     if4.div_by_zero, if4.overflow, if4.busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {if1.in_ready, if4.in_ready}, 2'b11);
    @(negedge clk);
    issue(1'b0, 32'hFFFF_8000, 32'd300, 5'd11);
    watch(1'b0, 32'hFFFF_8000, 32'd300, 5'd11, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
